dual_port_ram_reader: RTL and testbench

Burst read engine for one port of the team's `dual_port_ram` (1-cycle registered read, no read enable). It drives the port's address and consumes `q` for `length` consecutive words starting at `start_address`, wrapping at the top of memory. It presents the words on a valid/ready stream, and a 2-entry output buffer absorbs the RAM read latency under backpressure. The other RAM port remains free for a writer.

---
 rtl/dual_port_ram_reader.sv | 175 +++++++++++++++++
 tb/tb_dual_port_ram_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram_reader.sv
// ============================================================================
// dual_port_ram_reader
//
// Burst read engine for one port of the dual_port_ram (1-cycle registered
// read, no read enable). After a start request it walks `length` consecutive
// addresses from `start_address`, wrapping at the top of memory, and hands
// the returned words to a valid/ready consumer. A 2-entry output buffer
// absorbs the one-cycle RAM latency so that backpressure never loses a word.
//
// Ports
//   clock          in   rising-edge clock, shared with the RAM
//   reset_n        in   asynchronous active-low reset
//   start          in   burst request, only looked at while idle
//   start_address  in   first word address, captured with start
//   length         in   number of words (0 .. 2^ADDR_WIDTH), captured with start
//   busy           out  burst in progress
//   done           out  one-cycle pulse after the last word is accepted
//   ram_address    out  read address to the RAM port
//   ram_q          in   read data from the RAM port
//   out_data       out  head word of the output buffer
//   out_valid      out  output buffer holds at least one word
//   out_ready      in   consumer accepts out_data when out_valid is high
// ============================================================================
module dual_port_ram_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_address,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] ptr_q,       ptr_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [1:0]            count_q,     count_d;
    logic                  inflight_q,  inflight_d;
    logic                  head_q,      head_d;
    logic [DATA_WIDTH-1:0] buf0_q,      buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q,      buf1_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    logic       pop;
    logic       issue;
    logic       tailIdx;
    logic [2:0] occupancy;
    logic [2:0] afterPop;

    // Buffer occupancy plus the word still in the RAM pipeline. Issuing is
    // allowed only while that total, minus a word leaving this edge, stays
    // below two, so the returning word always has a free slot.
    always_comb begin
        pop       = out_valid && out_ready;
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        afterPop  = occupancy - {2'b00, pop};
        issue     = (state_q == StRead) && (remaining_q != '0) && (afterPop < 3'd2);
        // A capture only happens with inflight set, which limits count to 0
        // or 1, so the tail slot is the head flipped by the count LSB.
        tailIdx   = head_q ^ count_q[0];
    end

    // Next-state logic: buffer bookkeeping, read issue and the burst FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        count_d     = afterPop[1:0];
        inflight_d  = issue;
        head_d      = head_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (inflight_q) begin
            if (tailIdx) begin
                buf1_d = ram_q;
            end else begin
                buf0_d = ram_q;
            end
        end

        if (pop) begin
            head_d = ~head_q;
        end

        if (issue) begin
            ptr_d       = ptr_q + ADDR_WIDTH'(1);
            remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
        end

        case (state_q)
            StIdle: begin
                // A zero-length request completes on the spot: no pointer
                // load, no reads, just the done pulse next cycle.
                if (start) begin
                    if (length != '0) begin
                        state_d     = StRead;
                        ptr_d       = start_address;
                        remaining_d = length;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StRead: begin
                if (issue && (remaining_q == (ADDR_WIDTH+1)'(1))) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The burst ends when the final buffered word leaves and
                // nothing is left in the RAM pipeline.
                if (pop && !inflight_q && (count_q == 2'd1)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any burst in progress without a done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            inflight_q  <= 1'b0;
            head_q      <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            head_q      <= head_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ram_address = ptr_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_data    = head_q ? buf1_q : buf0_q;

endmodule

// File: tb/tb_dual_port_ram_reader.sv
// ============================================================================
// tb_dual_port_ram_reader
//
// Drives directed and random bursts into dual_port_ram_reader against a
// behavioural RAM with a one-cycle registered read. The expected word stream
// is simply mem[(start + i) mod depth] for each burst, held in a queue.
// ============================================================================
module tb_dual_port_ram_reader;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] start_address;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    logic [DW-1:0] mem [0:DEPTH-1];

    int checks = 0;
    int errors = 0;

    // Free-running clock.
    always #5 clock = ~clock;

    // Behavioural RAM port: registered read, no enable.
    always @(posedge clock) ram_q <= mem[ram_address];

    dual_port_ram_reader #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .start_address(start_address),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .ram_address  (ram_address),
        .ram_q        (ram_q),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    // One comparison: counts it, and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Consumer behaviour: always ready, fixed 1,0,0,1,0,1,1 pattern, or random.
    function automatic logic readyFor(input int mode, input int c);
        logic r;
        r = 1'b1;
        if (mode == 1) begin
            case (c % 7)
                1, 2, 4: r = 1'b0;
                default: r = 1'b1;
            endcase
        end else if (mode == 2) begin
            r = 1'($urandom_range(0, 1));
        end
        return r;
    endfunction

    // Runs one burst from a falling edge and checks it cycle by cycle.
    // abortAfter > 0 resets the block right after that many words;
    // ignoreAt >= 0 pulses a conflicting start in that cycle.
    task automatic applyStimulus(input int sa, input int len, input int mode,
                                 input int abortAfter, input int ignoreAt);
        logic [DW-1:0] expQ[$];
        logic [AW-1:0] addrQ[$];
        logic [AW-1:0] addrBefore;
        logic [DW-1:0] heldData;
        logic          held;
        logic          rdy;
        int            popped;
        int            doneCycle;
        int            budget;
        bit            finished;

        held     = 1'b0;
        heldData = '0;
        popped   = 0;
        finished = 1'b0;
        for (int i = 0; i < len; i++) expQ.push_back(mem[(sa + i) % DEPTH]);
        addrBefore = ram_address;
        doneCycle  = (len == 0) ? 0 : -1;
        budget     = len * 8 + 20;

        start         = 1'b1;
        start_address = AW'(sa);
        length        = (AW+1)'(len);
        @(negedge clock);

        for (int c = 0; c < budget && !finished; c++) begin
            rdy       = readyFor(mode, c);
            out_ready = rdy;
            if (c == ignoreAt) begin
                start         = 1'b1;
                start_address = AW'(sa + 300);
                length        = (AW+1)'(5);
            end else begin
                start = 1'b0;
            end

            checkOutput("done", {31'd0, done}, {31'd0, doneCycle == c});
            checkOutput("busy", {31'd0, busy}, {31'd0, doneCycle < 0});
            if (held) begin
                checkOutput("valid_hold", {31'd0, out_valid}, 32'd1);
                checkOutput("data_hold", {24'd0, out_data}, {24'd0, heldData});
            end
            if (len == 0) begin
                checkOutput("zero_valid", {31'd0, out_valid}, 32'd0);
                checkOutput("zero_addr", {22'd0, ram_address}, {22'd0, addrBefore});
            end
            if (addrQ.size() == 0 || addrQ[$] !== ram_address) addrQ.push_back(ram_address);

            held     = out_valid && !rdy;
            heldData = out_data;

            if (out_valid && rdy) begin
                checkOutput("word_expected", {31'd0, expQ.size() != 0}, 32'd1);
                if (expQ.size() != 0) checkOutput("data", {24'd0, out_data}, {24'd0, expQ.pop_front()});
                popped++;
                if (mode == 0) checkOutput("pop_cycle", c, popped + 1);
                if (expQ.size() == 0 && popped == len) doneCycle = c + 1;
                if (abortAfter > 0 && popped == abortAfter) begin
                    @(posedge clock);
                    #1 reset_n = 1'b0;
                    #1;
                    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
                    checkOutput("rst_done", {31'd0, done}, 32'd0);
                    checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
                    checkOutput("rst_data", {24'd0, out_data}, 32'd0);
                    checkOutput("rst_addr", {22'd0, ram_address}, 32'd0);
                    @(negedge clock);
                    checkOutput("rst_no_done", {31'd0, done}, 32'd0);
                    checkOutput("rst_no_valid", {31'd0, out_valid}, 32'd0);
                    reset_n = 1'b1;
                    return;
                end
            end

            if (doneCycle == c) finished = 1'b1;
            if (!finished) @(negedge clock);
        end

        checks++;
        assert (finished) else begin
            errors++;
            $error("[TB] FAIL timeout: observed no done within %0d cycles, required done", budget);
        end
        checkOutput("left_words", expQ.size(), 0);
        if (len > 0) begin
            checkOutput("addr_count", addrQ.size(), len + 1);
            for (int i = 0; i < addrQ.size() && i <= len; i++)
                checkOutput("addr_seq", {22'd0, addrQ[i]}, (sa + i) % DEPTH);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        start_address = '0;
        length        = '0;
        out_ready     = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(0, 255));
        #2;
        checkOutput("init_busy", {31'd0, busy}, 32'd0);
        checkOutput("init_done", {31'd0, done}, 32'd0);
        checkOutput("init_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("init_data", {24'd0, out_data}, 32'd0);
        checkOutput("init_addr", {22'd0, ram_address}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] basic burst");
        mem[4] = 8'hA0; mem[5] = 8'hA1; mem[6] = 8'hA2; mem[7] = 8'hA3;
        applyStimulus(4, 4, 0, 0, -1);

        $display("[TB] backpressure");
        applyStimulus(4, 4, 1, 0, -1);

        $display("[TB] wrap-around");
        mem[1022] = 8'd11; mem[1023] = 8'd22; mem[0] = 8'd33; mem[1] = 8'd44;
        applyStimulus(1022, 4, 0, 0, -1);

        $display("[TB] zero length");
        applyStimulus(100, 0, 0, 0, -1);

        $display("[TB] ignored start");
        applyStimulus(8, 4, 0, 0, 1);

        $display("[TB] random bursts");
        for (int k = 0; k < 6; k++)
            applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 24)), 2, 0, -1);
        applyStimulus(1015, 16, 1, 0, -1);

        $display("[TB] reset mid-burst");
        applyStimulus(10, 8, 0, 2, -1);
        applyStimulus(0, 2, 0, 0, -1);

        $display("[TB] full memory");
        applyStimulus(512, DEPTH, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
